// File: rtl/ex_alu_stage.sv
// EX-stage ALU feeding the EX/MEM register: 1-cycle latency, valid/ready, in_ready = !out_valid || out_ready, flush/rst squash.
// Define EX_ALU_OVF_EN to add the registered signed add/sub overflow flag out_ovf.
module ex_alu_stage #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [4:0]      in_rd,
  input  logic            in_regwrite,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_zero,
  output logic [4:0]      out_rd,
  output logic            out_regwrite,
  output logic            out_illegal
`ifdef EX_ALU_OVF_EN
  ,
  output logic            out_ovf
`endif
);

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic            zero;
    logic [4:0]      rd;
    logic            regwrite;
    logic            illegal;
`ifdef EX_ALU_OVF_EN
    logic            ovf;
`endif
  } ex_mem_t;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t  state_q, state_d;
  ex_mem_t exm_q, exm_d;

  logic [SHAMT_W-1:0] shamt;
  logic [XLEN-1:0]    alu_res;
  logic               alu_illegal;
  logic               transfer;

  assign shamt    = in_b[SHAMT_W-1:0];
  assign transfer = in_valid && in_ready;

  always_comb begin
    alu_res     = '0;
    alu_illegal = 1'b0;
    // Plain case: X/Z op bits match no item and fall to the illegal default.
    case (in_op)
      4'b0010: alu_res = in_a + in_b;
      4'b0110: alu_res = in_a - in_b;
      4'b0000: alu_res = in_a & in_b;
      4'b0001: alu_res = in_a | in_b;
      4'b0111: alu_res = in_a ^ in_b;
      4'b0011: alu_res = in_a << shamt;
      4'b0100: alu_res = in_a >> shamt;
      4'b0101: alu_res = $unsigned($signed(in_a) >>> shamt);
      4'b1100: alu_res = {{(XLEN-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
      4'b1101: alu_res = {{(XLEN-1){1'b0}}, (in_a < in_b)};
      default: begin
        alu_res     = '0;
        alu_illegal = 1'b1;
      end
    endcase
  end

  always_comb begin
    exm_d          = exm_q;
    exm_d.result   = alu_res;
    exm_d.zero     = (alu_res == '0);
    exm_d.rd       = in_rd;
    exm_d.regwrite = in_regwrite && !alu_illegal;
    exm_d.illegal  = alu_illegal;
`ifdef EX_ALU_OVF_EN
    exm_d.ovf = 1'b0;
    if (in_op == 4'b0010)
      exm_d.ovf = (in_a[XLEN-1] == in_b[XLEN-1]) && (alu_res[XLEN-1] != in_a[XLEN-1]);
    else if (in_op == 4'b0110)
      exm_d.ovf = (in_a[XLEN-1] != in_b[XLEN-1]) && (alu_res[XLEN-1] != in_a[XLEN-1]);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY:   if (transfer) state_d = FULL;
        FULL:    if (transfer) state_d = FULL;
                 else if (out_ready) state_d = EMPTY;
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    out_valid = (state_q == FULL);
    in_ready  = (state_q == EMPTY) || out_ready;
  end

  // Payload moves only on a real, unsquashed transfer so bubbles do not toggle it.
  always_ff @(posedge clk) begin
    if (rst) begin
      exm_q      <= '0;
      exm_q.zero <= 1'b1;
    end else if (transfer && !flush) begin
      exm_q <= exm_d;
    end
  end

  assign out_result   = exm_q.result;
  assign out_zero     = exm_q.zero;
  assign out_rd       = exm_q.rd;
  assign out_regwrite = exm_q.regwrite;
  assign out_illegal  = exm_q.illegal;
`ifdef EX_ALU_OVF_EN
  assign out_ovf      = exm_q.ovf;
`endif

endmodule

// File: tb/tb_ex_alu_stage.sv
// Directed bench for ex_alu_stage: reset, op table, stall, stream, flush, illegal/overflow.
module tb_ex_alu_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [31:0] in_a, in_b;
  logic [4:0]  in_rd;
  logic        in_regwrite;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic [4:0]  out_rd;
  logic        out_regwrite;
  logic        out_illegal;
`ifdef EX_ALU_OVF_EN
  logic        out_ovf;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [3:0] OP_ADD = 4'b0010, OP_SUB = 4'b0110, OP_AND = 4'b0000,
                         OP_OR = 4'b0001, OP_XOR = 4'b0111, OP_SLL = 4'b0011,
                         OP_SRL = 4'b0100, OP_SRA = 4'b0101, OP_SLT = 4'b1100,
                         OP_SLTU = 4'b1101;

  ex_alu_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_rd(in_rd), .in_regwrite(in_regwrite), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_rd(out_rd), .out_regwrite(out_regwrite),
    .out_illegal(out_illegal)
`ifdef EX_ALU_OVF_EN
    , .out_ovf(out_ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_rd = rd; in_regwrite = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(OP_ADD, 32'd5, 32'd6, 5'd9);
    step(); step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    checks++; if (out_zero !== 1'b1) begin errors++; $display("FAIL reset_zero got %b exp 1", out_zero); end
    checks++; if (out_result !== 32'h0) begin errors++; $display("FAIL reset_result got %h exp 0", out_result); end
    checks++; if ({out_rd, out_regwrite, out_illegal} !== 7'h0)
      begin errors++; $display("FAIL reset_fields got rd=%0d rw=%b ill=%b exp 0", out_rd, out_regwrite, out_illegal); end
`ifdef EX_ALU_OVF_EN
    checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", out_ovf); end
`endif
    in_valid = 1'b0;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_alu_ops();
    logic [3:0]  ops [10];
    logic [31:0] as  [10];
    logic [31:0] bs  [10];
    logic [31:0] exp [10];
    ops[0] = OP_ADD;  as[0] = 32'h8000_0000; bs[0] = 32'd4;  exp[0] = 32'h8000_0004;
    ops[1] = OP_SUB;  as[1] = 32'h8000_0000; bs[1] = 32'd4;  exp[1] = 32'h7FFF_FFFC;
    ops[2] = OP_SRA;  as[2] = 32'h8000_0000; bs[2] = 32'd4;  exp[2] = 32'hF800_0000;
    ops[3] = OP_SRL;  as[3] = 32'h8000_0000; bs[3] = 32'd4;  exp[3] = 32'h0800_0000;
    ops[4] = OP_SLT;  as[4] = 32'h8000_0000; bs[4] = 32'd1;  exp[4] = 32'h1;
    ops[5] = OP_SLTU; as[5] = 32'h8000_0000; bs[5] = 32'd1;  exp[5] = 32'h0;
    ops[6] = OP_AND;  as[6] = 32'hF0F0_F0F0; bs[6] = 32'h0FF0_0FF0; exp[6] = 32'h00F0_00F0;
    ops[7] = OP_OR;   as[7] = 32'hF0F0_F0F0; bs[7] = 32'h0FF0_0FF0; exp[7] = 32'hFFF0_FFF0;
    ops[8] = OP_XOR;  as[8] = 32'hF0F0_F0F0; bs[8] = 32'h0FF0_0FF0; exp[8] = 32'hFF00_FF00;
    ops[9] = OP_SLL;  as[9] = 32'h0000_0001; bs[9] = 32'h0000_0024; exp[9] = 32'h0000_0010;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(ops[i], as[i], bs[i], 5'(i + 1));
      step();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL op%0d_valid got %b exp 1", i, out_valid); end
      checks++; if (out_result !== exp[i]) begin errors++; $display("FAIL op%0d_result got %h exp %h", i, out_result, exp[i]); end
      checks++; if (out_zero !== (exp[i] == 32'h0)) begin errors++; $display("FAIL op%0d_zero got %b", i, out_zero); end
      checks++; if (out_rd !== 5'(i + 1) || out_regwrite !== 1'b1 || out_illegal !== 1'b0)
        begin errors++; $display("FAIL op%0d_fields got rd=%0d rw=%b ill=%b exp rd=%0d rw=1 ill=0", i, out_rd, out_regwrite, out_illegal, i + 1); end
    end
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ops_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_stall();
    out_ready = 1'b1;
    drive(OP_ADD, 32'd10, 32'd20, 5'd3);
    step();
    out_ready = 1'b0;
    drive(OP_ADD, 32'd1, 32'd2, 5'd4);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready got %b exp 0", in_ready); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (out_valid !== 1'b1 || out_result !== 32'd30 || out_rd !== 5'd3 || in_ready !== 1'b0)
        begin errors++; $display("FAIL stall_hold%0d got v=%b r=%0d rd=%0d rdy=%b exp v=1 r=30 rd=3 rdy=0", i, out_valid, out_result, out_rd, in_ready); end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready got %b exp 1", in_ready); end
    step();
    checks++; if (out_valid !== 1'b1 || out_result !== 32'd3 || out_rd !== 5'd4)
      begin errors++; $display("FAIL stall_next got v=%b r=%0d rd=%0d exp v=1 r=3 rd=4", out_valid, out_result, out_rd); end
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(OP_ADD, 32'(i), 32'd100, 5'(i + 10));
      step();
      checks++; if (out_valid !== 1'b1 || out_result !== 32'(100 + i) || out_rd !== 5'(i + 10))
        begin errors++; $display("FAIL stream%0d got v=%b r=%0d rd=%0d exp v=1 r=%0d rd=%0d", i, out_valid, out_result, out_rd, 100 + i, i + 10); end
    end
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    drive(OP_ADD, 32'd5, 32'd5, 5'd7);
    step();
    drive(OP_ADD, 32'd6, 32'd6, 5'd8);
    flush = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %b exp 1", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b exp 0", out_valid); end
    flush = 1'b0; in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_nodeliver got %b exp 0", out_valid); end
    // Flush while stalled.
    drive(OP_ADD, 32'd1, 32'd1, 5'd2);
    step();
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_stall got %b exp 0", out_valid); end
    // Reset while stalled drops the held result.
    out_ready = 1'b1;
    drive(OP_ADD, 32'd40, 32'd2, 5'd5);
    step();
    in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0; out_ready = 1'b1;
    checks++; if (out_valid !== 1'b0 || out_result !== 32'h0 || out_zero !== 1'b1)
      begin errors++; $display("FAIL rst_stall got v=%b r=%h z=%b exp v=0 r=0 z=1", out_valid, out_result, out_zero); end
  endtask

  task automatic test_illegal_ovf();
    out_ready = 1'b1;
    drive(4'b1111, 32'd5, 32'd3, 5'd6);
    step();
    checks++; if (out_valid !== 1'b1 || out_illegal !== 1'b1 || out_regwrite !== 1'b0)
      begin errors++; $display("FAIL illegal_flags got v=%b ill=%b rw=%b exp v=1 ill=1 rw=0", out_valid, out_illegal, out_regwrite); end
    checks++; if (out_result !== 32'h0 || out_zero !== 1'b1 || out_rd !== 5'd6)
      begin errors++; $display("FAIL illegal_result got r=%h z=%b rd=%0d exp r=0 z=1 rd=6", out_result, out_zero, out_rd); end
    drive(4'b1000, 32'd5, 32'd3, 5'd6);
    step();
    checks++; if (out_illegal !== 1'b1 || out_result !== 32'h0)
      begin errors++; $display("FAIL illegal_1000 got ill=%b r=%h exp ill=1 r=0", out_illegal, out_result); end
    drive(OP_ADD, 32'h7FFF_FFFF, 32'd1, 5'd1);
    step();
    checks++; if (out_result !== 32'h8000_0000 || out_illegal !== 1'b0)
      begin errors++; $display("FAIL ovf_add_result got r=%h ill=%b exp r=80000000 ill=0", out_result, out_illegal); end
`ifdef EX_ALU_OVF_EN
    checks++; if (out_ovf !== 1'b1) begin errors++; $display("FAIL ovf_add got %b exp 1", out_ovf); end
    drive(OP_SUB, 32'h8000_0000, 32'd1, 5'd1);
    step();
    checks++; if (out_ovf !== 1'b1 || out_result !== 32'h7FFF_FFFF)
      begin errors++; $display("FAIL ovf_sub got ovf=%b r=%h exp ovf=1 r=7fffffff", out_ovf, out_result); end
    drive(OP_ADD, 32'd1, 32'd2, 5'd1);
    step();
    checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL ovf_none got %b exp 0", out_ovf); end
`endif
    in_valid = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1; in_valid = 1'b0;
    in_op = 4'b0; in_a = '0; in_b = '0; in_rd = '0; in_regwrite = 1'b0;
    test_reset();
    test_alu_ops();
    test_stall();
    test_back_to_back();
    test_flush();
    test_illegal_ovf();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
